// File: rtl/sha_pkg.sv
`default_nettype none
// ============================================================================
// sha_pkg : shared FSM state, constant-table locations and word type
// Revision: 1.0
// ============================================================================
package sha_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_FETCH    = 2'd2,
    ST_DRAIN    = 2'd3
  } state_e;

  localparam logic [7:0] H_BASE  = 8'd0;
  localparam int         H_COUNT = 8;
  localparam logic [7:0] K_BASE  = 8'd64;
  localparam int         K_COUNT = 64;

  typedef logic [31:0] word_t;

  localparam int IDX_W = 6;

  // Extra bits stored per FIFO entry beside the data word: last flag (+ index).
`ifdef WORD_READER_IDX_EN
  localparam int ENTRY_EXTRA = 1 + IDX_W;
`else
  localparam int ENTRY_EXTRA = 1;
`endif

endpackage
`default_nettype wire

// File: rtl/mod_word_fifo.sv
`default_nettype none
// ============================================================================
// mod_word_fifo : registered synchronous FIFO (no bypass), power-of-two depth
// Revision: 1.0
// ============================================================================
module mod_word_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle makes room for a push into a full FIFO.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PTR_W + 1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (PTR_W + 1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mod_word_reader.sv
`default_nettype none
// ============================================================================
// mod_word_reader : streams a burst of 32-bit words from the four-bank RAM
//                   onto a valid/ready interface. Optional macro
//                   WORD_READER_IDX_EN adds the out_idx_o burst-index port.
// Revision: 1.0
// ============================================================================
module mod_word_reader
  import sha_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              mem_ready_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [6:0]        count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              re_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o
`ifdef WORD_READER_IDX_EN
  ,
  output logic [IDX_W-1:0]  out_idx_o
`endif
);

  localparam int FIFO_W = DATA_W + ENTRY_EXTRA;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int INF_W  = $clog2(RD_LAT + 1) + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [6:0]          cnt_q, cnt_d;
  logic [6:0]          issued_q, issued_d;
  logic [6:0]          pushed_q, pushed_d;
  logic [RD_LAT-1:0]   vld_q;
  logic [INF_W-1:0]    in_flight;
  logic                re;
  logic                push;
  logic                pop;
  logic                credit_ok;
  logic                last_flag;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FCNT_W-1:0]   fifo_count;
  logic [FIFO_W-1:0]   fifo_din;
  logic [FIFO_W-1:0]   fifo_head;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + INF_W'(vld_q[i]);
  end

  // Every issued read owns a FIFO slot until it is popped, so the FIFO can never overflow.
  assign credit_ok = !fifo_full && ((int'(fifo_count) + int'(in_flight)) < FIFO_DEPTH);
  assign re        = (state_q == ST_FETCH) && mem_ready_i && (issued_q != cnt_q) && credit_ok;
  assign push      = vld_q[RD_LAT-1];
  assign pop       = !fifo_empty && out_ready_i;
  assign last_flag = (pushed_q == cnt_q - 7'd1);

`ifdef WORD_READER_IDX_EN
  assign fifo_din  = {last_flag, pushed_q[IDX_W-1:0], rdata_i};
  assign out_idx_o = fifo_head[DATA_W +: IDX_W];
`else
  assign fifo_din  = {last_flag, rdata_i};
`endif

  mod_word_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .data_i  (fifo_din),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    issued_d = issued_q;
    pushed_d = push ? pushed_q + 7'd1 : pushed_q;
    done_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && (count_i != 7'd0)) begin
          base_d   = base_addr_i;
          cnt_d    = count_i;
          issued_d = 7'd0;
          pushed_d = 7'd0;
          state_d  = mem_ready_i ? ST_FETCH : ST_WAIT_MEM;
        end
      end
      ST_WAIT_MEM: begin
        if (mem_ready_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (re) begin
          issued_d = issued_q + 7'd1;
          if (issued_q + 7'd1 == cnt_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((in_flight == '0) && fifo_empty) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      cnt_q    <= '0;
      issued_q <= '0;
      pushed_q <= '0;
      vld_q    <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
      pushed_q <= pushed_d;
      vld_q[0] <= re;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign re_o        = re;
  assign addr_o      = base_q + ADDR_W'(issued_q);
  assign out_valid_o = !fifo_empty;
  assign out_data_o  = fifo_head[DATA_W-1:0];
  assign out_last_o  = fifo_head[FIFO_W-1];

endmodule
`default_nettype wire

// File: doc/mod_word_reader.md
Name: mod_word_reader

Overview:
- Reads a burst of 32-bit words out of the four-bank byte RAM filled by the memory manager. Bank 1 holds the MSB and bank 4 the LSB; all banks share one address.
- Streams the words to the SHA-256 round logic over a valid/ready interface. Examples: H constants (base 0, 8 words) or K constants (base 64, 64 words).
- This is the read-side counterpart to the memory manager's ROM-to-RAM write path.
- Holds a small internal FIFO so downstream backpressure never drops a word in flight.

Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 32, word width (four 8-bit banks)
- FIFO_DEPTH, 4, output FIFO entries; minimum 2, power of two
- RD_LAT, 1, RAM read latency in cycles (RE/ADDR to RDATA valid)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- MEM_READY  in  1  high once ROM copy is complete (tie to COPY_ROM_COMPLETE)
- START  in  1  one-cycle pulse; begins a burst
- BASE_ADDR  in  ADDR_W  first word address, sampled on START
- COUNT  in  7  number of words, 1..64, sampled on START
- BUSY  out  1  high from accepted START until the last word is handed off
- DONE  out  1  one-cycle pulse on the cycle after the last handshake
- RE  out  1  RAM read enable
- ADDR  out  ADDR_W  RAM read address
- RDATA  in  DATA_W  {bank_1,bank_2,bank_3,bank_4} read data
- OUT_VALID  out  1  word available
- OUT_READY  in  1  consumer accepts
- OUT_DATA  out  DATA_W  word
- OUT_LAST  out  1  qualifies the final word of the burst

Behaviour:
- Reset (async assert, sync release): state IDLE. BUSY, DONE, RE, OUT_VALID, OUT_LAST are 0. ADDR is 0, OUT_DATA is 0. FIFO is empty and all counters are 0.
- FSM states:
  - IDLE: START with COUNT!=0 latches base and count, then goes to WAIT_MEM. START with COUNT==0 is ignored: no BUSY, no DONE.
  - WAIT_MEM: holds until MEM_READY=1, then goes to FETCH. Enters FETCH in the same cycle if MEM_READY is already high when START is accepted.
  - FETCH: issues one read per cycle (RE=1, ADDR=base+issued). Issue condition: fifo_count + in_flight < FIFO_DEPTH. Moves to DRAIN when issued==count.
  - DRAIN: RE=0; waits until all in-flight reads have landed and the FIFO has emptied, then goes to IDLE with DONE=1 for one cycle.
- RDATA is captured into the FIFO exactly RD_LAT cycles after the RE cycle, via an RD_LAT-deep valid shift register.
- Throughput: with OUT_READY held high, sustains 1 word per clock. First OUT_VALID appears RD_LAT+1 cycles after the first RE; the FIFO is registered with no bypass.
- Output interface:
  - OUT_DATA/OUT_LAST come from the FIFO head. OUT_VALID = FIFO not empty.
  - Once OUT_VALID is asserted, the word stays stable until the handshake (OUT_VALID && OUT_READY).
- OUT_LAST is 1 only on the word whose burst index == count-1.
- Address arithmetic is modulo 2^ADDR_W: base 0xFE with count 4 reads 0xFE, 0xFF, 0x00, 0x01.
- START while BUSY=1 is ignored.
- Simultaneous FIFO push and pop while full is legal: a pop frees a slot in the same cycle for credit purposes on the next issue.
- MEM_READY falling while in FETCH: issuing pauses (RE=0) and resumes when it rises; data already in flight is still captured.
- Reset mid-burst: everything is discarded immediately and the block returns to IDLE. No DONE is generated.

Optional Feature:
- Macro: WORD_READER_IDX_EN.
- Defined: adds output port OUT_IDX (6 bits), the burst index (0..count-1) of the head word, stored alongside the data in the FIFO. Index counters are 7 bits.
- Not defined: no OUT_IDX port and no index storage in the FIFO. OUT_LAST still comes from a single stored flag bit.

Decomposition:
- Shared package (sha_pkg):
  - FSM state enum (IDLE, WAIT_MEM, FETCH, DRAIN)
  - H_BASE=8'd0, H_COUNT=8, K_BASE=8'd64, K_COUNT=64
  - Word type (32 bits)
- Sub-module: mod_word_fifo, a synchronous FIFO of width DATA_W+1 (+6 with WORD_READER_IDX_EN) and depth FIFO_DEPTH. Exposes full, empty and count.

Test Plan:
- Preload RAM with H/K constants, MEM_READY=1; START base=0 count=8, OUT_READY=1 -> words 0x6a09e667 ... 0x5be0cd19 on 8 consecutive cycles. OUT_LAST only with 0x5be0cd19; DONE pulses once.
- START base=64 count=64, OUT_READY toggling 1/0 each cycle -> all 64 K words, 0x428a2f98 ... 0xc67178f2, in order with none dropped or duplicated. RE never issued with fifo_count+in_flight >= FIFO_DEPTH.
- START with MEM_READY=0, then raise it 10 cycles later -> RE stays 0 until MEM_READY=1; the stream then matches the H constants.
- Write 0xAA000001 at 0xFF and 0xBB000002 at 0x00; START base=0xFF count=2 -> outputs 0xAA000001 then 0xBB000002 with OUT_LAST.
- Assert RST_N=0 after 5 words of a K burst, then release -> all outputs at reset values. Next START base=0 count=1 yields 0x6a09e667 with OUT_LAST=1.
- START count=0, and a second START pulsed mid-burst -> both ignored; BUSY/DONE unaffected and the original stream is intact.
